avalon_lsu: RTL and testbench

AVALON_LSU -- requirements
Module: avalon_lsu

---
 rtl/avalon_lsu.sv | 201 ++++++++++++++++++++
 tb/tb_avalon_lsu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_lsu.sv
// Load/store unit bridging a CPU byte-addressed access to a 32-bit Avalon-MM master port.
// Handles lane selection, store replication, load extension, alignment checks and a stall timeout.
module avalon_lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    localparam logic [1:0] EC_ALIGN   = 2'd1;
    localparam logic [1:0] EC_ILLEGAL = 2'd2;
    localparam logic [1:0] EC_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, FIN} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt, cnt_d;
    logic [3:0]      op_q;
    logic [1:0]      addr_lo_q;
    logic            read_d, write_d, done_d, err_d;
    logic [1:0]      err_code_d;
    logic            accept, load_rdata, timeout_c;
    size_t           size_c;
    logic            illegal_c, misaligned_c;
    logic [3:0]      be_c;
    logic [31:0]     wd_c, ext_c;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;

    // Request decode: access size, legality, lane enables and replicated store data
    always_comb begin
        case (op)
            OP_LB, OP_LBU, OP_SB: size_c = SZ_B;
            OP_LH, OP_LHU, OP_SH: size_c = SZ_H;
            OP_LW, OP_SW:         size_c = SZ_W;
            default:              size_c = SZ_BAD;
        endcase
        illegal_c    = (size_c == SZ_BAD);
        misaligned_c = ((size_c == SZ_H) && addr[0]) || ((size_c == SZ_W) && (addr[1:0] != 2'b00));
        case (size_c)
            SZ_B:    be_c = 4'b0001 << addr[1:0];
            SZ_H:    be_c = addr[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
        case (size_c)
            SZ_B:    wd_c = {4{wdata[7:0]}};
            SZ_H:    wd_c = {2{wdata[15:0]}};
            default: wd_c = wdata;
        endcase
    end

    // Load result: pick the addressed lane(s) and extend per the captured op
    always_comb begin
        lane_byte = readdata[{addr_lo_q, 3'b000} +: 8];
        lane_half = addr_lo_q[1] ? readdata[31:16] : readdata[15:0];
        case (op_q)
            OP_LB:   ext_c = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  ext_c = {24'd0, lane_byte};
            OP_LH:   ext_c = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  ext_c = {16'd0, lane_half};
            default: ext_c = readdata;
        endcase
    end

    assign timeout_c = (MAX_WAIT != 0) && waitrequest && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code;
        cnt_d      = wait_cnt;
        accept     = 1'b0;
        load_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (illegal_c) begin
                        state_d    = FIN;
                        err_d      = 1'b1;
                        err_code_d = EC_ILLEGAL;
                    end else if (misaligned_c) begin
                        state_d    = FIN;
                        err_d      = 1'b1;
                        err_code_d = EC_ALIGN;
                    end else begin
                        accept = 1'b1;
                        cnt_d  = '0;
                        if (op[3]) begin
                            state_d = WR_REQ;
                            write_d = 1'b1;
                        end else begin
                            state_d = RD_REQ;
                            read_d  = 1'b1;
                        end
                    end
                end
            end
            RD_REQ, WR_REQ: begin
                if (!waitrequest) begin
                    if (state_q == RD_REQ) begin
                        state_d = RD_DATA;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_d    = FIN;
                    err_d      = 1'b1;
                    err_code_d = EC_TIMEOUT;
                end else begin
                    read_d  = (state_q == RD_REQ);
                    write_d = (state_q == WR_REQ);
                    // Saturate so a disabled timeout never wraps the counter
                    cnt_d   = (wait_cnt == {CW{1'b1}}) ? wait_cnt : wait_cnt + CW'(1);
                end
            end
            RD_DATA: begin
                state_d    = FIN;
                done_d     = 1'b1;
                load_rdata = 1'b1;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and captured request fields
    always_ff @(posedge clk) begin
        if (reset) begin
            read       <= 1'b0;
            write      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            err_code   <= 2'd0;
            wait_cnt   <= '0;
            rdata      <= 32'd0;
            address    <= 32'd0;
            writedata  <= 32'd0;
            byteenable <= 4'b0000;
            op_q       <= 4'd0;
            addr_lo_q  <= 2'd0;
        end else begin
            read     <= read_d;
            write    <= write_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= (state_d != IDLE);
            err_code <= err_code_d;
            wait_cnt <= cnt_d;
            if (accept) begin
                op_q       <= op;
                addr_lo_q  <= addr[1:0];
                address    <= {addr[31:2], 2'b00};
                byteenable <= be_c;
                writedata  <= wd_c;
            end
            if (load_rdata) rdata <= ext_c;
        end
    end

endmodule

// File: tb/tb_avalon_lsu.sv
// Scoreboard bench for avalon_lsu: two instances (default and MAX_WAIT=3), a stalling slave model
// and a monitor that matches every strobe and completion against queued expectations.
module tb_avalon_lsu;

    typedef struct {
        string       name;
        int          inst;
        bit          is_err;
        logic [1:0]  code;
        bit          keep_rdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] address;
        logic [31:0] wd;
        int          issue;
        int          lat;
        int          rdc;
        int          wrc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v [2];
    logic [3:0]  op;
    logic [31:0] addr, wdata, readdata;
    logic        waitrequest;
    logic        busy_v [2], done_v [2], err_v [2], read_v [2], write_v [2];
    logic [1:0]  err_code_v [2];
    logic [31:0] rdata_v [2], address_v [2], writedata_v [2];
    logic [3:0]  byteenable_v [2];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   sel      = 0;
    int   stall_left = 0;
    bit   allow_orphan = 1'b0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    logic [31:0] mdl_rdata [2];
    exp_t q [$];

    avalon_lsu u_dut0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .err(err_v[0]),
        .err_code(err_code_v[0]), .address(address_v[0]), .read(read_v[0]), .write(write_v[0]),
        .waitrequest(waitrequest), .writedata(writedata_v[0]), .byteenable(byteenable_v[0]),
        .readdata(readdata)
    );

    avalon_lsu #(.MAX_WAIT(3)) u_dut1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .err(err_v[1]),
        .err_code(err_code_v[1]), .address(address_v[1]), .read(read_v[1]), .write(write_v[1]),
        .waitrequest(waitrequest), .writedata(writedata_v[1]), .byteenable(byteenable_v[1]),
        .readdata(readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Slave model: stall the selected instance's strobe for stall_left cycles, then accept
    always @(negedge clk) begin
        if ((read_v[sel] || write_v[sel]) && stall_left > 0) begin
            waitrequest = 1'b1;
            stall_left--;
        end else begin
            waitrequest = 1'b0;
        end
    end

    // Monitor: check bus fields while strobing, and the response on every done/err pulse
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (read_v[sel] || write_v[sel] || done_v[sel] || err_v[sel]) begin
                check("rd_wr_exclusive", 32'(read_v[sel] && write_v[sel]), 32'd0);
                check("done_err_exclusive", 32'(done_v[sel] && err_v[sel]), 32'd0);
            end
            if (read_v[sel] || write_v[sel]) begin
                if (q.size() == 0) begin
                    if (!allow_orphan) begin
                        n_checks++;
                        $display("FAIL unexpected_strobe: read=%0b write=%0b with nothing expected",
                                 read_v[sel], write_v[sel]);
                    end
                end else begin
                    e = q[0];
                    rd_cnt += int'(read_v[sel]);
                    wr_cnt += int'(write_v[sel]);
                    check({e.name, "_address"}, address_v[sel], e.address);
                    check({e.name, "_byteenable"}, 32'(byteenable_v[sel]), 32'(e.be));
                    if (write_v[sel]) check({e.name, "_writedata"}, writedata_v[sel], e.wd);
                end
            end
            if (done_v[sel] || err_v[sel]) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_completion: done=%0b err=%0b with nothing expected",
                             done_v[sel], err_v[sel]);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_err"}, 32'(err_v[sel]), 32'(e.is_err));
                    if (e.is_err) check({e.name, "_err_code"}, 32'(err_code_v[sel]), 32'(e.code));
                    check({e.name, "_rdata"}, rdata_v[sel], e.rdata);
                    check({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
                    check({e.name, "_read_cycles"}, 32'(rd_cnt), 32'(e.rdc));
                    check({e.name, "_write_cycles"}, 32'(wr_cnt), 32'(e.wrc));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    function automatic exp_t mk(input string name, input bit is_err, input logic [1:0] code,
                                input bit keep, input logic [31:0] r, input logic [3:0] be,
                                input logic [31:0] ad, input logic [31:0] wd,
                                input int lat, input int rdc, input int wrc);
        exp_t e;
        e.name = name;  e.inst = 0;  e.is_err = is_err;  e.code = code;
        e.keep_rdata = keep;  e.rdata = r;  e.be = be;  e.address = ad;  e.wd = wd;
        e.issue = 0;  e.lat = lat;  e.rdc = rdc;  e.wrc = wrc;
        return e;
    endfunction

    task automatic run(input int inst, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rd, input int stalls,
                       input bit hold, input exp_t e_in);
        exp_t e;
        bit   ok;
        e  = e_in;
        ok = 1'b0;
        @(posedge clk);
        #1;
        sel = inst;  op = o;  addr = a;  wdata = w;  readdata = rd;  stall_left = stalls;
        e.inst  = inst;
        e.issue = cyc;
        if (e.keep_rdata) e.rdata = mdl_rdata[inst];
        else              mdl_rdata[inst] = e.rdata;
        q.push_back(e);
        req_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_v[inst] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy_v[inst]) begin
                ok = 1'b1;
                break;
            end
        end
        req_v[inst] = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_complete: busy still 1 after 60 cycles", e.name);
        end
    endtask

    initial begin
        reset = 1'b1;  req_v[0] = 1'b0;  req_v[1] = 1'b0;
        op = 4'd0;  addr = 32'd0;  wdata = 32'd0;  readdata = 32'd0;  waitrequest = 1'b0;
        mdl_rdata[0] = 32'd0;  mdl_rdata[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ctrl", 32'({busy_v[i], read_v[i], write_v[i], done_v[i], err_v[i], err_code_v[i]}), 32'd0);
            check("rst_rdata", rdata_v[i], 32'd0);
            check("rst_address", address_v[i], 32'd0);
            check("rst_writedata", writedata_v[i], 32'd0);
            check("rst_byteenable", 32'(byteenable_v[i]), 32'd0);
        end
        reset = 1'b0;

        //  inst op     addr          wdata         readdata      stall hold
        run(0, 4'd0,  32'h00000006, 32'h0,        32'h12F45678, 0, 0,
            mk("lb_lane2", 0, 2'd0, 0, 32'hFFFFFFF4, 4'b0100, 32'h00000004, 32'h0, 3, 1, 0));
        run(0, 4'd1,  32'h00000007, 32'h0,        32'h80F45678, 0, 0,
            mk("lbu_lane3", 0, 2'd0, 0, 32'h00000080, 4'b1000, 32'h00000004, 32'h0, 3, 1, 0));
        run(0, 4'd2,  32'h00000102, 32'h0,        32'h9ABC1234, 0, 0,
            mk("lh_upper", 0, 2'd0, 0, 32'hFFFF9ABC, 4'b1100, 32'h00000100, 32'h0, 3, 1, 0));
        run(0, 4'd3,  32'h00000000, 32'h0,        32'h9ABC8765, 0, 0,
            mk("lhu_lower", 0, 2'd0, 0, 32'h00008765, 4'b0011, 32'h00000000, 32'h0, 3, 1, 0));
        run(0, 4'd4,  32'h80000010, 32'h0,        32'hDEADBEEF, 0, 0,
            mk("lw", 0, 2'd0, 0, 32'hDEADBEEF, 4'b1111, 32'h80000010, 32'h0, 3, 1, 0));
        run(0, 4'd0,  32'h00000000, 32'h0,        32'h0000007F, 2, 0,
            mk("lb_stall2", 0, 2'd0, 0, 32'h0000007F, 4'b0001, 32'h00000000, 32'h0, 5, 3, 0));
        run(0, 4'd8,  32'h00000003, 32'h000012A5, 32'h0,        0, 0,
            mk("sb_lane3", 0, 2'd0, 1, 32'h0, 4'b1000, 32'h00000000, 32'hA5A5A5A5, 2, 0, 1));
        run(0, 4'd9,  32'h0000000A, 32'h0000BEEF, 32'h0,        4, 1,
            mk("sh_stall4", 0, 2'd0, 1, 32'h0, 4'b1100, 32'h00000008, 32'hBEEFBEEF, 6, 0, 5));
        run(0, 4'd10, 32'h00000020, 32'h01234567, 32'h0,        0, 0,
            mk("sw", 0, 2'd0, 1, 32'h0, 4'b1111, 32'h00000020, 32'h01234567, 2, 0, 1));
        run(0, 4'd4,  32'h00000002, 32'h0,        32'h0,        0, 0,
            mk("lw_misaligned", 1, 2'd1, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 0));
        run(0, 4'd5,  32'h00000000, 32'h0,        32'h0,        0, 0,
            mk("op5_illegal", 1, 2'd2, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 0));
        run(0, 4'd9,  32'h00000001, 32'h0,        32'h0,        0, 0,
            mk("sh_misaligned", 1, 2'd1, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 0));
        run(0, 4'd15, 32'h00000003, 32'h0,        32'h0,        0, 0,
            mk("illegal_over_misalign", 1, 2'd2, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 0));
        run(1, 4'd3,  32'h00000002, 32'h0,        32'h80010000, 0, 0,
            mk("lhu_mw3", 0, 2'd0, 0, 32'h00008001, 4'b1100, 32'h00000000, 32'h0, 3, 1, 0));
        run(1, 4'd4,  32'h00000004, 32'h0,        32'h55555555, 1000, 0,
            mk("lw_timeout", 1, 2'd3, 1, 32'h0, 4'b1111, 32'h00000004, 32'h0, 4, 3, 0));

        // Reset in the middle of a stalled read on the MAX_WAIT=3 instance
        sel = 1;  allow_orphan = 1'b1;  op = 4'd0;  addr = 32'h0;  stall_left = 1000;
        @(posedge clk);
        #1 req_v[1] = 1'b1;
        @(posedge clk);
        #1 req_v[1] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_read_before", 32'(read_v[1]), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_reset_read_after", 32'(read_v[1]), 32'd0);
        check("mid_reset_busy", 32'(busy_v[1]), 32'd0);
        check("mid_reset_rdata", rdata_v[1], 32'd0);
        check("mid_reset_address", address_v[1], 32'd0);
        check("mid_reset_byteenable", 32'(byteenable_v[1]), 32'd0);
        stall_left = 0;
        allow_orphan = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
